// File: rtl/regfile_write_decoder_if.sv
// Write-port bundle for the 32 x WIDTH register file.
// The master drives the write strobe, address and data.
// The slave returns the full register image and the decoded enable.
interface regfile_write_decoder_if #(
  parameter int WIDTH = 64
);
  logic                        RegWrite;
  logic [4:0]                  WriteRegister;
  logic [WIDTH-1:0]            WriteData;
  logic [31:0][WIDTH-1:0]      regs_out;
  logic [31:0]                 wr_en_onehot;

  modport master (
    output RegWrite,
    output WriteRegister,
    output WriteData,
    input  regs_out,
    input  wr_en_onehot
  );

  modport slave (
    input  RegWrite,
    input  WriteRegister,
    input  WriteData,
    output regs_out,
    output wr_en_onehot
  );
endinterface

// File: rtl/regfile_write_decoder.sv
// Write side of the 32 x WIDTH register file.
// A tree decoder turns WriteRegister into a one-hot enable. 31 enabled flop
// banks hold the architectural registers. Register ZERO_REG is hardwired
// to zero and owns no storage.
module regfile_write_decoder #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_write_decoder_if.slave bus
);

  // Decoder tree.
  // sel[4] picks a half, then sel[3:2] picks a group of four registers,
  // then sel[1:0] picks a register inside that group.
  logic [1:0]  hi_en;
  logic [7:0]  mid_en;
  logic [31:0] dec_raw;
  logic [31:0] wr_en;

  genvar gi, gj;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_hi
      assign hi_en[gi] = bus.RegWrite & (bus.WriteRegister[4] == 1'(gi));
    end

    for (gi = 0; gi < 8; gi++) begin : g_mid
      assign mid_en[gi] = hi_en[gi / 4] & (bus.WriteRegister[3:2] == 2'(gi % 4));
    end

    // Eight 2-to-4 leaf decoders, each enabled by its group select.
    for (gi = 0; gi < 8; gi++) begin : g_leaf
      for (gj = 0; gj < 4; gj++) begin : g_bit
        assign dec_raw[gi * 4 + gj] = mid_en[gi] & (bus.WriteRegister[1:0] == 2'(gj));
      end
    end
  endgenerate

  // The zero register never sees an enable, so a write to it has no effect.
  assign wr_en            = dec_raw & ~(32'h1 << ZERO_REG);
  assign bus.wr_en_onehot = wr_en;

  // Storage: one enabled register per architectural register, except ZERO_REG.
  generate
    for (gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == ZERO_REG) begin : g_zero
        assign bus.regs_out[gi] = '0;
      end else begin : g_flop
        logic [WIDTH-1:0] reg_q;
        logic [WIDTH-1:0] reg_d;

        // Load WriteData when this register is selected, otherwise hold.
        always_comb reg_d = wr_en[gi] ? bus.WriteData : reg_q;

        // Clear at once on reset; no bypass, so new data is visible after the edge.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) reg_q <= '0;
          else       reg_q <= reg_d;
        end

        assign bus.regs_out[gi] = reg_q;
      end
    end
  endgenerate

endmodule
